// File: rtl/fetch_sequencer.sv
// Instruction fetch/decode/execute sequencer driving PC control strobes.
// Strobes decode from the registered state and IR, so each is held a full clock period.
module fetch_sequencer #(
  parameter int unsigned MEM_TIMEOUT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  input  logic        exec_done,
  input  logic        cond_true,
  output logic        mem_req,
  output logic [15:0] ir,
  output logic        exec_start,
  output logic        pc_reset,
  output logic        pc_load,
  output logic        pc_jump,
  output logic        pc_inc,
  output logic        halted,
  output logic        fault,
  output logic [15:0] instr_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_UPDATE,
    S_PAUSE,
    S_HALT,
    S_FAULT
  } state_t;

  localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_wait;
  logic        r_cond;
  logic [15:0] r_ir;
  logic [15:0] r_count;
  logic [3:0]  w_op;

  assign w_op        = r_ir[15:12];
  assign ir          = r_ir;
  assign instr_count = r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // An ack in the final wait cycle takes priority over the timeout.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (run) w_next = S_FETCH;
      S_FETCH: begin
        if (mem_ack)                 w_next = S_DECODE;
        else if (r_wait == TMO_LAST) w_next = S_FAULT;
      end
      S_DECODE: w_next = (w_op == 4'hF) ? S_HALT : S_EXEC;
      S_EXEC:   if (exec_done) w_next = S_UPDATE;
      S_UPDATE: w_next = run ? S_FETCH : S_PAUSE;
      S_PAUSE:  if (run) w_next = S_FETCH;
      S_HALT:   w_next = S_HALT;
      S_FAULT:  w_next = S_FAULT;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wait  <= '0;
      r_cond  <= 1'b0;
      r_ir    <= '0;
      r_count <= '0;
    end else begin
      r_wait <= (r_state == S_FETCH && !mem_ack) ? r_wait + 8'd1 : '0;
      if (r_state == S_FETCH && mem_ack)  r_ir    <= mem_rdata;
      if (r_state == S_EXEC && exec_done) r_cond  <= cond_true;
      if (r_state == S_UPDATE)            r_count <= r_count + 16'd1;
    end
  end

  always_comb begin
    mem_req    = 1'b0;
    exec_start = 1'b0;
    pc_reset   = 1'b0;
    pc_load    = 1'b0;
    pc_jump    = 1'b0;
    pc_inc     = 1'b0;
    halted     = 1'b0;
    fault      = 1'b0;
    case (r_state)
      S_IDLE:   pc_reset   = 1'b1;
      S_FETCH:  mem_req    = 1'b1;
      S_DECODE: exec_start = (w_op != 4'hF);
      S_UPDATE: begin
        if (w_op == 4'hE)                pc_load = 1'b1;
        else if (w_op == 4'hD && r_cond) pc_jump = 1'b1;
        else                             pc_inc  = 1'b1;
      end
      S_HALT:   halted     = 1'b1;
      S_FAULT:  fault      = 1'b1;
      default:  ;
    endcase
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: per-cycle expected outputs from an instruction-level model.
module tb_fetch_sequencer;

  localparam int unsigned TMO = 8;

  logic        clk = 1'b0;
  logic        reset, run, mem_ack, exec_done, cond_true;
  logic [15:0] mem_rdata;
  logic        mem_req, exec_start, pc_reset, pc_load, pc_jump, pc_inc, halted, fault;
  logic [15:0] ir, instr_count;

  always #5 clk = ~clk;

  fetch_sequencer #(.MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .run(run), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .exec_done(exec_done), .cond_true(cond_true), .mem_req(mem_req), .ir(ir),
    .exec_start(exec_start), .pc_reset(pc_reset), .pc_load(pc_load), .pc_jump(pc_jump),
    .pc_inc(pc_inc), .halted(halted), .fault(fault), .instr_count(instr_count)
  );

  typedef enum {K_IDLE, K_FETCH, K_DECODE, K_EXEC, K_UPDATE, K_PAUSE, K_HALT, K_FAULT} kind_t;

  int errors = 0;
  int checks = 0;
  int n_inc = 0, n_jump = 0, n_load = 0;
  int b_inc, b_jump, b_load;

  logic [15:0] m_ir, m_count;
  logic [1:0]  m_strobe;   // 1 inc, 2 jump, 3 load
  logic e_mem_req, e_exec_start, e_pc_reset, e_pc_load, e_pc_jump, e_pc_inc, e_halted, e_fault;

  function automatic void chk(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endfunction

  function automatic logic [1:0] strobe_for(input logic [15:0] word, input logic c);
    if (word[15:12] == 4'hE)      return 2'd3;
    if (word[15:12] == 4'hD && c) return 2'd2;
    return 2'd1;
  endfunction

  function automatic void expect_k(input kind_t k);
    e_mem_req    = (k == K_FETCH);
    e_exec_start = (k == K_DECODE) && (m_ir[15:12] != 4'hF);
    e_pc_reset   = (k == K_IDLE);
    e_pc_inc     = (k == K_UPDATE) && (m_strobe == 2'd1);
    e_pc_jump    = (k == K_UPDATE) && (m_strobe == 2'd2);
    e_pc_load    = (k == K_UPDATE) && (m_strobe == 2'd3);
    e_halted     = (k == K_HALT);
    e_fault      = (k == K_FAULT);
  endfunction

  always @(negedge clk) begin
    chk("mem_req", 16'(mem_req), 16'(e_mem_req));
    chk("exec_start", 16'(exec_start), 16'(e_exec_start));
    chk("pc_reset", 16'(pc_reset), 16'(e_pc_reset));
    chk("pc_load", 16'(pc_load), 16'(e_pc_load));
    chk("pc_jump", 16'(pc_jump), 16'(e_pc_jump));
    chk("pc_inc", 16'(pc_inc), 16'(e_pc_inc));
    chk("halted", 16'(halted), 16'(e_halted));
    chk("fault", 16'(fault), 16'(e_fault));
    chk("ir", ir, m_ir);
    chk("instr_count", instr_count, m_count);
    chk("pc_onehot0", 16'($countones({pc_reset, pc_load, pc_jump, pc_inc}) <= 1), 16'd1);
    if (pc_inc)  n_inc++;
    if (pc_jump) n_jump++;
    if (pc_load) n_load++;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic snap();
    b_inc = n_inc; b_jump = n_jump; b_load = n_load;
  endtask

  task automatic do_reset();
    reset = 1'b1; run = 1'b0; mem_ack = 1'b0; exec_done = 1'b0; cond_true = 1'b0;
    mem_rdata = '0; m_ir = '0; m_count = '0; m_strobe = 2'd1;
    expect_k(K_IDLE);
    tick();
    tick();
    reset = 1'b0;
    expect_k(K_IDLE);
    tick();
  endtask

  // Applies reset between edges and checks outputs before the next rising edge.
  task automatic async_reset(input string tag);
    reset = 1'b1;
    m_ir = '0; m_count = '0;
    expect_k(K_IDLE);
    #2;
    chk({tag, "_pc_reset"}, 16'(pc_reset), 16'd1);
    chk({tag, "_mem_req"}, 16'(mem_req), 16'd0);
    chk({tag, "_exec_start"}, 16'(exec_start), 16'd0);
    chk({tag, "_count"}, instr_count, 16'd0);
    chk({tag, "_ir"}, ir, 16'd0);
    tick();
    reset = 1'b0; run = 1'b0; mem_ack = 1'b0; exec_done = 1'b0;
    expect_k(K_IDLE);
    tick();
  endtask

  // Enters FETCH on the next edge, acks after ack_dly idle FETCH cycles, ends in DECODE.
  task automatic fetch_phase(input logic [15:0] word, input int unsigned ack_dly);
    run = 1'b1; mem_ack = 1'b0;
    expect_k(K_FETCH);
    tick();
    repeat (ack_dly) begin
      mem_ack = 1'b0;
      expect_k(K_FETCH);
      tick();
    end
    mem_ack = 1'b1; mem_rdata = word; m_ir = word;
    expect_k(K_DECODE);
    tick();
    mem_ack = 1'b0; mem_rdata = 16'hDEAD;
  endtask

  // From DECODE: a stray exec_done in DECODE must be ignored; done arrives exec_dly cycles after exec_start.
  task automatic exec_phase(input int unsigned exec_dly, input logic c, input logic run_in,
                            input logic run_after);
    exec_done = 1'b1; cond_true = ~c; run = run_in;
    expect_k(K_EXEC);
    tick();
    repeat (exec_dly - 1) begin
      exec_done = 1'b0;
      expect_k(K_EXEC);
      tick();
    end
    exec_done = 1'b1; cond_true = c;
    m_strobe = strobe_for(m_ir, c);
    expect_k(K_UPDATE);
    tick();
    exec_done = 1'b0; cond_true = 1'b0; run = run_after;
    m_count = m_count + 16'd1;
  endtask

  task automatic pause_phase(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      run = 1'b0; exec_done = i[0];
      expect_k(K_PAUSE);
      tick();
    end
    exec_done = 1'b0;
  endtask

  task automatic terminal_phase(input kind_t k, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      run = ~run; mem_ack = i[0]; exec_done = ~i[0]; mem_rdata = 16'h0BAD;
      expect_k(k);
      tick();
    end
    mem_ack = 1'b0; exec_done = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    chk("rst_pc_reset", 16'(pc_reset), 16'd1);
    chk("rst_ir", ir, 16'h0000);
    chk("rst_count", instr_count, 16'h0000);
    chk("rst_mem_req", 16'(mem_req), 16'd0);

    snap();
    fetch_phase(16'h1234, 2);
    exec_phase(3, 1'b0, 1'b1, 1'b1);
    chk("r29_ir", ir, 16'h1234);
    fetch_phase(16'hD000, 0);
    chk("r29_inc_pulses", 16'(n_inc - b_inc), 16'd1);
    chk("r29_count", instr_count, 16'd1);

    snap();
    exec_phase(2, 1'b1, 1'b1, 1'b1);
    fetch_phase(16'hD000, 1);
    chk("r30_jump_pulses", 16'(n_jump - b_jump), 16'd1);
    chk("r30_jump_no_inc", 16'(n_inc - b_inc), 16'd0);
    snap();
    exec_phase(1, 1'b0, 1'b1, 1'b1);
    fetch_phase(16'hE005, 0);
    chk("r30_inc_pulses", 16'(n_inc - b_inc), 16'd1);
    chk("r30_count", instr_count, 16'd3);

    snap();
    exec_phase(2, 1'b1, 1'b1, 1'b1);
    fetch_phase(16'h0042, 0);
    chk("r31_load_pulses", 16'(n_load - b_load), 16'd1);
    chk("r31_load_only", 16'(n_inc - b_inc + n_jump - b_jump), 16'd0);

    exec_phase(3, 1'b0, 1'b0, 1'b0);
    pause_phase(3);
    chk("r33_pause_mem_req", 16'(mem_req), 16'd0);
    chk("r33_count", instr_count, 16'd5);

    snap();
    fetch_phase(16'hF000, 1);
    terminal_phase(K_HALT, 6);
    chk("r31_halted", 16'(halted), 16'd1);
    chk("r31_halt_count", instr_count, 16'd5);
    chk("r31_halt_strobes", 16'(n_inc - b_inc + n_jump - b_jump + n_load - b_load), 16'd0);

    async_reset("rst_halt");
    chk("rst_halt_cleared", 16'(halted), 16'd0);

    run = 1'b1; mem_ack = 1'b0;
    expect_k(K_FETCH);
    tick();
    repeat (TMO - 1) begin
      mem_ack = 1'b0;
      expect_k(K_FETCH);
      tick();
    end
    mem_ack = 1'b0;
    expect_k(K_FAULT);
    tick();
    terminal_phase(K_FAULT, 5);
    chk("r32_fault", 16'(fault), 16'd1);
    chk("r32_fault_mem_req", 16'(mem_req), 16'd0);

    async_reset("rst_fault");
    fetch_phase(16'h2222, TMO - 1);
    chk("r32_late_ack_fault", 16'(fault), 16'd0);
    chk("r32_late_ack_ir", ir, 16'h2222);
    exec_phase(1, 1'b0, 1'b1, 1'b1);

    run = 1'b1; mem_ack = 1'b0;
    expect_k(K_FETCH);
    tick();
    mem_ack = 1'b0;
    expect_k(K_FETCH);
    tick();
    async_reset("rst_fetch");

    fetch_phase(16'h1111, 0);
    exec_phase(1, 1'b0, 1'b1, 1'b1);
    fetch_phase(16'h3333, 0);
    exec_done = 1'b0;
    expect_k(K_EXEC);
    tick();
    exec_done = 1'b0;
    expect_k(K_EXEC);
    tick();
    async_reset("rst_exec");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
